max_pool_row_buf: RTL and testbench

// - Vertical pairing stage directly upstream of the max-pool unit.
// - Buffers the even row of a raster-order feature-map stream in a row RAM.
// - On the following odd row it presents the stored pixel (data_1_o) and the live pixel (data_2_o), column by column, with max_en_o set.
// - Horizontal reduction is done downstream; this block only pairs rows r and r+1.

---
 rtl/max_pool_row_buf_pkg.sv | 22 ++
 rtl/max_pool_row_buf_if.sv | 32 +++
 rtl/max_pool_row_buf_ram.sv | 27 ++
 rtl/max_pool_row_buf.sv | 153 +++++++++++++++
 tb/tb_max_pool_row_buf.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/max_pool_row_buf_pkg.sv
// Shared types and constants for the max-pool row pairing stage.
package max_pool_row_buf_pkg;

    localparam int LANE_W  = 12;
    localparam int N_LANES = 4;
    localparam int WORD_W  = LANE_W * N_LANES;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_MERGE,
        ST_TAIL,
        ST_PASS
    } state_t;

    // Address width for a RAM of the given depth (at least one bit).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/max_pool_row_buf_if.sv
// Pixel stream in, paired pixel stream out, plus frame control/status.
interface max_pool_row_buf_if #(
    parameter int DIM_W = 7
);
    import max_pool_row_buf_pkg::*;

    logic              start_i;
    logic [DIM_W-1:0]  dim_i;
    logic              pool_en_i;
    logic [WORD_W-1:0] data_i;
    logic              data_valid_i;

    logic [WORD_W-1:0] data_1_o;
    logic [WORD_W-1:0] data_2_o;
    logic              max_en_o;
    logic              data_valid_o;
    logic              busy_o;
    logic              done_o;

    // Upstream source / stimulus side.
    modport master (
        output start_i, dim_i, pool_en_i, data_i, data_valid_i,
        input  data_1_o, data_2_o, max_en_o, data_valid_o, busy_o, done_o
    );

    // Pairing stage side.
    modport slave (
        input  start_i, dim_i, pool_en_i, data_i, data_valid_i,
        output data_1_o, data_2_o, max_en_o, data_valid_o, busy_o, done_o
    );

endinterface

// File: rtl/max_pool_row_buf_ram.sv
// Simple dual-port row RAM: one write port, one registered read port.
module max_pool_row_buf_ram
    import max_pool_row_buf_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Write on request; read data registered and held while rd_en is low.
    // NOTE: no reset on the array or read register so this maps onto block RAM;
    // every location is written in a FILL row before the MERGE row reads it.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/max_pool_row_buf.sv
// Pairs row r (buffered) with row r+1 (live) for a downstream vertical max.
module max_pool_row_buf
    import max_pool_row_buf_pkg::*;
#(
    parameter int MAX_W = 64,
    parameter int DIM_W = 7
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    max_pool_row_buf_if.slave  bus
);

    localparam int ADDR_W = addr_w(MAX_W);

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  dim_q;
    logic [DIM_W-1:0]  col_q;
    logic [DIM_W-1:0]  row_q;

    logic              start_ok;
    logic              accept;
    logic              end_of_row;
    logic              last_row;
    logic              next_is_last;
    logic              emit;
    logic              ram_wr_en;
    logic              ram_rd_en;

    logic [WORD_W-1:0] ram_rd_data;
    logic [WORD_W-1:0] pass_q;
    logic [WORD_W-1:0] data_2_q;
    logic              src_ram_q;
    logic              max_en_q;
    logic              valid_q;
    logic              done_q;

    assign start_ok     = (state_q == ST_IDLE) && bus.start_i && (bus.dim_i != '0);
    assign accept       = (state_q != ST_IDLE) && bus.data_valid_i;
    assign end_of_row   = (col_q == dim_q - DIM_W'(1));
    assign last_row     = (row_q == dim_q - DIM_W'(1));
    // Only consulted in MERGE, where dim >= 2.
    assign next_is_last = (row_q == dim_q - DIM_W'(2));
    assign emit         = accept && (state_q != ST_FILL);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state and RAM port control; an even row that is also the last row
    // has no partner and is sent straight out through TAIL.
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        ram_wr_en = 1'b0;
        ram_rd_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    if (!bus.pool_en_i)              state_d = ST_PASS;
                    else if (bus.dim_i == DIM_W'(1)) state_d = ST_TAIL;
                    else                             state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                ram_wr_en = accept;
                if (accept && end_of_row) state_d = ST_MERGE;
            end
            ST_MERGE: begin
                ram_rd_en = accept;
                if (accept && end_of_row) begin
                    if (last_row)          state_d = ST_IDLE;
                    else if (next_is_last) state_d = ST_TAIL;
                    else                   state_d = ST_FILL;
                end
            end
            ST_TAIL: begin
                if (accept && end_of_row) state_d = ST_IDLE;
            end
            ST_PASS: begin
                if (accept && end_of_row && last_row) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame geometry: latch width at start, walk col/row per accepted pixel.
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dim_q <= '0;
            col_q <= '0;
            row_q <= '0;
        end else if (start_ok) begin
            dim_q <= bus.dim_i;
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (end_of_row) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_q + DIM_W'(1);
            end else begin
                col_q <= col_q + DIM_W'(1);
            end
        end
    end

    // Output alignment: live pixel and flags delayed one cycle to line up
    // with the synchronous RAM read; values hold across input gaps.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pass_q    <= '0;
            data_2_q  <= '0;
            src_ram_q <= 1'b0;
            max_en_q  <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            valid_q <= emit;
            done_q  <= accept && end_of_row && last_row;
            if (emit) begin
                src_ram_q <= (state_q == ST_MERGE);
                max_en_q  <= (state_q == ST_MERGE);
                pass_q    <= bus.data_i;
                data_2_q  <= (state_q == ST_MERGE) ? bus.data_i : '0;
            end
        end
    end

    max_pool_row_buf_ram #(
        .DEPTH  (MAX_W),
        .ADDR_W (ADDR_W)
    ) u_row_buf_ram (
        .clk_i   (clk_i),
        .wr_en   (ram_wr_en),
        .wr_addr (col_q[ADDR_W-1:0]),
        .wr_data (bus.data_i),
        .rd_en   (ram_rd_en),
        .rd_addr (col_q[ADDR_W-1:0]),
        .rd_data (ram_rd_data)
    );

    assign bus.data_1_o     = src_ram_q ? ram_rd_data : pass_q;
    assign bus.data_2_o     = data_2_q;
    assign bus.max_en_o     = max_en_q;
    assign bus.data_valid_o = valid_q;
    assign bus.done_o       = done_q;
    assign bus.busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_max_pool_row_buf.sv
// Self-checking bench: raster frames against a row-pairing reference model.
module tb_max_pool_row_buf;
    import max_pool_row_buf_pkg::*;

    localparam int MAX_W = 64;
    localparam int DIM_W = 7;

    typedef struct packed {
        logic [WORD_W-1:0] d1;
        logic [WORD_W-1:0] d2;
        logic              en;
        logic              done;
        logic              busy;
    } out_t;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    max_pool_row_buf_if #(.DIM_W(DIM_W)) bus();

    max_pool_row_buf #(
        .MAX_W (MAX_W),
        .DIM_W (DIM_W)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   done_cnt = 0;
    out_t got_q[$];
    int   got_cyc_q[$];
    out_t mon_o;
    logic [WORD_W-1:0] pix [MAX_W*MAX_W];
    int   in_cyc [MAX_W*MAX_W];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Capture every valid output (with its cycle) away from the clock edge.
    always @(negedge clk_i) begin
        if (bus.data_valid_o === 1'b1) begin
            mon_o = {bus.data_1_o, bus.data_2_o, bus.max_en_o, bus.done_o, bus.busy_o};
            got_q.push_back(mon_o);
            got_cyc_q.push_back(cyc);
        end
        if (bus.done_o === 1'b1) done_cnt++;
    end

    // One frame: build pixels, model expected pairs, drive, compare.
    task automatic run_frame(input int dim, input bit pool, input int gap_mode,
                             input bit poke, input bit pattern, input string name);
        out_t e;
        out_t exp_q[$];
        int   src_q[$];
        int   idx;
        bit   tog;
        bit   gap;

        for (int r = 0; r < dim; r++)
            for (int c = 0; c < dim; c++)
                pix[r*dim+c] = pattern ? {N_LANES{LANE_W'(16*r + c)}}
                                       : WORD_W'({$urandom(), $urandom()});

        // Reference: rows taken two at a time, odd leftover row alone.
        if (pool) begin
            for (int r = 0; r < dim; r += 2)
                for (int c = 0; c < dim; c++) begin
                    e = '0;
                    e.d1 = pix[r*dim+c];
                    if (r + 1 < dim) begin
                        e.d2 = pix[(r+1)*dim+c];
                        e.en = 1'b1;
                        src_q.push_back((r+1)*dim+c);
                    end else begin
                        src_q.push_back(r*dim+c);
                    end
                    exp_q.push_back(e);
                end
        end else begin
            for (int i = 0; i < dim*dim; i++) begin
                e = '0;
                e.d1 = pix[i];
                exp_q.push_back(e);
                src_q.push_back(i);
            end
        end
        foreach (exp_q[i]) begin
            exp_q[i].done = (i == exp_q.size() - 1);
            exp_q[i].busy = !exp_q[i].done;
        end

        got_q.delete();
        got_cyc_q.delete();
        done_cnt = 0;
        bus.start_i      = 1'b1;
        bus.dim_i        = DIM_W'(dim);
        bus.pool_en_i    = pool;
        bus.data_valid_i = 1'b0;
        @(negedge clk_i);
        bus.start_i   = 1'b0;
        bus.dim_i     = DIM_W'($urandom_range(1, MAX_W));
        bus.pool_en_i = !pool;
        idx = 0;
        tog = 1'b0;
        while (idx < dim*dim) begin
            gap = (gap_mode == 1) ? tog : (gap_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            tog = !tog;
            bus.start_i = poke && (idx == dim + 1);
            if (bus.start_i) bus.dim_i = DIM_W'(2);
            if (gap) begin
                bus.data_valid_i = 1'b0;
                bus.data_i       = WORD_W'({$urandom(), $urandom()});
            end else begin
                bus.data_valid_i = 1'b1;
                bus.data_i       = pix[idx];
                in_cyc[idx]      = cyc;
                idx++;
            end
            @(negedge clk_i);
        end
        bus.data_valid_i = 1'b0;
        bus.start_i      = 1'b0;
        repeat (3) @(negedge clk_i);

        check({name, ":n_out"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s:out%0d", name, i), got_q[i], exp_q[i]);
            check($sformatf("%s:lat%0d", name, i), got_cyc_q[i], in_cyc[src_q[i]] + 1);
        end
        check({name, ":done_cnt"}, done_cnt, 1);
        check({name, ":busy_end"}, bus.busy_o, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1);
    end

    initial begin
        bus.start_i      = 1'b0;
        bus.dim_i        = '0;
        bus.pool_en_i    = 1'b0;
        bus.data_i       = '0;
        bus.data_valid_i = 1'b0;
        rst_n_i          = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_valid", bus.data_valid_o, 1'b0);
        check("rst_busy",  bus.busy_o,       1'b0);
        check("rst_done",  bus.done_o,       1'b0);
        check("rst_max_en", bus.max_en_o,    1'b0);
        check("rst_data_1", bus.data_1_o,    '0);
        check("rst_data_2", bus.data_2_o,    '0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Pixels while idle produce nothing.
        got_q.delete();
        bus.data_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.data_i = WORD_W'({$urandom(), $urandom()});
            @(negedge clk_i);
        end
        bus.data_valid_i = 1'b0;
        @(negedge clk_i);
        check("idle_no_out", got_q.size(), 0);
        check("idle_busy",   bus.busy_o, 1'b0);

        // Start with zero width is ignored.
        bus.start_i   = 1'b1;
        bus.dim_i     = '0;
        bus.pool_en_i = 1'b1;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        @(negedge clk_i);
        check("dim0_busy", bus.busy_o, 1'b0);

        run_frame(4, 1'b1, 0, 1'b0, 1'b1, "pool4");
        check("pool4_r1c2_d1", got_q[2].d1, {N_LANES{12'h002}});
        check("pool4_r1c2_d2", got_q[2].d2, {N_LANES{12'h012}});
        check("pool4_r1c2_en", got_q[2].en, 1'b1);

        run_frame(3, 1'b1, 0, 1'b0, 1'b1, "pool3");
        check("pool3_r2c0_d1", got_q[3].d1, {N_LANES{12'h020}});
        check("pool3_r2c0_d2", got_q[3].d2, '0);
        check("pool3_r2c0_en", got_q[3].en, 1'b0);

        run_frame(3, 1'b0, 0, 1'b0, 1'b1, "pass3");
        run_frame(4, 1'b1, 1, 1'b0, 1'b1, "toggle4");
        run_frame(4, 1'b1, 0, 1'b1, 1'b1, "poke4");

        // Reset during row 1 of a dim=4 pooled frame.
        bus.start_i   = 1'b1;
        bus.dim_i     = DIM_W'(4);
        bus.pool_en_i = 1'b1;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.data_valid_i = 1'b1;
            bus.data_i       = WORD_W'({$urandom(), $urandom()});
            @(negedge clk_i);
        end
        rst_n_i    = 1'b0;
        bus.data_i = WORD_W'({$urandom(), $urandom()});
        @(negedge clk_i);
        rst_n_i          = 1'b1;
        bus.data_valid_i = 1'b0;
        check("mid_rst_valid",  bus.data_valid_o, 1'b0);
        check("mid_rst_busy",   bus.busy_o,       1'b0);
        check("mid_rst_done",   bus.done_o,       1'b0);
        check("mid_rst_max_en", bus.max_en_o,     1'b0);
        check("mid_rst_data_1", bus.data_1_o,     '0);
        check("mid_rst_data_2", bus.data_2_o,     '0);
        got_q.delete();
        bus.data_valid_i = 1'b1;
        repeat (2) @(negedge clk_i);
        bus.data_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("post_rst_no_out", got_q.size(), 0);
        check("post_rst_busy",   bus.busy_o,   1'b0);
        run_frame(4, 1'b1, 0, 1'b0, 1'b1, "after_rst");

        run_frame(1, 1'b1, 0, 1'b0, 1'b0, "pool1");
        run_frame(1, 1'b0, 0, 1'b0, 1'b0, "pass1");
        run_frame(MAX_W, 1'b1, 0, 1'b0, 1'b0, "pool_max");

        for (int k = 0; k < 10; k++)
            run_frame($urandom_range(1, 9), 1'($urandom_range(0, 1)), 2, 1'b0, 1'b0,
                      $sformatf("rand%0d", k));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
